// File: rtl/ifetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encoding,
// parameter defaults and the timeout-counter width helper.
package ifetch_unit_pkg;

    localparam logic [31:0] DEF_RESET_PC = 32'h0040_0000;
    localparam int          DEF_TIMEOUT  = 255;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_HOLD  = 2'd2,
        ST_FAULT = 2'd3
    } fetch_state_t;

    // Counter width able to hold 0..TIMEOUT; never narrower than one bit.
    function automatic int timer_width(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/ifetch_unit_timer.sv
// REQ-phase watchdog: up-counter cleared when a request is launched,
// counting every cycle the request is outstanding. 'expired' marks the
// LIMIT-th outstanding cycle so the FSM can abandon the request at its end.
module ifetch_unit_timer
    import ifetch_unit_pkg::*;
#(
    parameter int LIMIT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic expired
);

    localparam int             W    = timer_width(LIMIT);
    localparam logic [W-1:0]   LAST = W'(LIMIT - 1);

    logic [W-1:0] count;

    // Clear has priority so a new request always starts from zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)        count <= '0;
        else if (clear) count <= '0;
        else if (en)    count <= count + 1'b1;
    end

    // A zero limit disables the watchdog entirely.
    always_comb begin
        expired = (LIMIT != 0) && en && (count == LAST);
    end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch unit: captures the PC on a start pulse, runs a
// req/ack read to instruction memory, holds the word in IR until the
// decoder takes it, then strobes PC+4 back to the PC register.
module ifetch_unit
    import ifetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEF_RESET_PC,
    parameter int          TIMEOUT  = DEF_TIMEOUT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_addr,
    input  logic        fetch_start,
    input  logic        flush,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        imem_err,
    output logic [31:0] ir_out,
    output logic        ir_valid,
    input  logic        ir_ready,
    output logic [31:0] pc_next,
    output logic        pc_load,
    output logic        busy,
    output logic        fault,
    output logic [31:0] fault_addr
);

    fetch_state_t state;
    logic         drop;       // flush seen while a read was in flight
    logic         start_ok;
    logic         tmr_expired;

    // Aligned start accepted from IDLE; flush in the same cycle wins.
    always_comb begin
        start_ok = (state == ST_IDLE) && fetch_start && !flush && (pc_addr[1:0] == 2'b00);
    end

    ifetch_unit_timer #(.LIMIT(TIMEOUT)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (start_ok),
        .en      (state == ST_REQ),
        .expired (tmr_expired)
    );

    // Fetch FSM with every output registered alongside the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            drop       <= 1'b0;
            imem_req   <= 1'b0;
            imem_addr  <= RESET_PC;
            ir_out     <= 32'h0;
            ir_valid   <= 1'b0;
            pc_next    <= RESET_PC + 32'd4;
            pc_load    <= 1'b0;
            busy       <= 1'b0;
            fault      <= 1'b0;
            fault_addr <= 32'h0;
        end else begin
            pc_load <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (fetch_start && !flush) begin
                        busy <= 1'b1;
                        if (pc_addr[1:0] == 2'b00) begin
                            imem_addr <= pc_addr;
                            imem_req  <= 1'b1;
                            state     <= ST_REQ;
                        end else begin
                            // Misaligned: fault without touching the bus.
                            fault      <= 1'b1;
                            fault_addr <= pc_addr;
                            state      <= ST_FAULT;
                        end
                    end
                end
                ST_REQ: begin
                    // The request is never withdrawn early; ack beats timeout.
                    if (imem_ack) begin
                        imem_req <= 1'b0;
                        drop     <= 1'b0;
                        if (imem_err) begin
                            fault      <= 1'b1;
                            fault_addr <= imem_addr;
                            state      <= ST_FAULT;
                        end else if (drop || flush) begin
                            busy  <= 1'b0;
                            state <= ST_IDLE;
                        end else begin
                            ir_out   <= imem_rdata;
                            ir_valid <= 1'b1;
                            state    <= ST_HOLD;
                        end
                    end else if (tmr_expired) begin
                        imem_req   <= 1'b0;
                        drop       <= 1'b0;
                        fault      <= 1'b1;
                        fault_addr <= imem_addr;
                        state      <= ST_FAULT;
                    end else if (flush) begin
                        drop <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (flush) begin
                        ir_valid <= 1'b0;
                        busy     <= 1'b0;
                        state    <= ST_IDLE;
                    end else if (ir_ready) begin
                        ir_valid <= 1'b0;
                        pc_load  <= 1'b1;
                        pc_next  <= imem_addr + 32'd4;
                        busy     <= 1'b0;
                        state    <= ST_IDLE;
                    end
                end
                ST_FAULT: begin
                    if (flush) begin
                        fault <= 1'b0;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: directed scenarios plus randomized fetch
// transactions checked against a transaction-level outcome model.
module tb_ifetch_unit;

    localparam logic [31:0] RPC = 32'h0040_0000;
    localparam int          TO  = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc_addr = 32'h0;
    logic        fetch_start = 1'b0;
    logic        flush = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        imem_err = 1'b0;
    logic [31:0] ir_out;
    logic        ir_valid;
    logic        ir_ready = 1'b0;
    logic [31:0] pc_next;
    logic        pc_load;
    logic        busy;
    logic        fault;
    logic [31:0] fault_addr;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] exp_pc_next = RPC + 32'd4;

    ifetch_unit #(.RESET_PC(RPC), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .pc_addr(pc_addr), .fetch_start(fetch_start), .flush(flush),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .imem_err(imem_err), .ir_out(ir_out), .ir_valid(ir_valid),
        .ir_ready(ir_ready), .pc_next(pc_next), .pc_load(pc_load), .busy(busy),
        .fault(fault), .fault_addr(fault_addr)
    );

    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        tick(); tick();
        n_vec++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL rst_req got=%b exp=0", imem_req); end
        n_vec++; if (imem_addr !== RPC) begin n_err++; $display("FAIL rst_addr got=%h exp=%h", imem_addr, RPC); end
        n_vec++; if (pc_next !== RPC + 32'd4) begin n_err++; $display("FAIL rst_pc_next got=%h exp=%h", pc_next, RPC + 32'd4); end
        n_vec++; if ({ir_valid, pc_load, busy, fault} !== 4'b0) begin n_err++; $display("FAIL rst_flags got=%b exp=0000", {ir_valid, pc_load, busy, fault}); end
        n_vec++; if ({ir_out, fault_addr} !== 64'h0) begin n_err++; $display("FAIL rst_regs got=%h exp=0", {ir_out, fault_addr}); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        pc_addr = 32'h0040_0000; fetch_start = 1'b1;
        tick(); fetch_start = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            n_vec++; if (imem_req !== 1'b1 || imem_addr !== 32'h0040_0000) begin n_err++; $display("FAIL basic_req c=%0d got=%b/%h exp=1/00400000", c, imem_req, imem_addr); end
            n_vec++; if (ir_valid !== 1'b0) begin n_err++; $display("FAIL basic_early_valid c=%0d got=%b exp=0", c, ir_valid); end
            if (c == 3) begin imem_ack = 1'b1; imem_rdata = 32'h2008_0005; end
            tick();
        end
        imem_ack = 1'b0;
        n_vec++; if (ir_valid !== 1'b1 || ir_out !== 32'h2008_0005) begin n_err++; $display("FAIL basic_ir got=%b/%h exp=1/20080005", ir_valid, ir_out); end
        n_vec++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL basic_req_drop got=%b exp=0", imem_req); end
        ir_ready = 1'b1;
        tick(); ir_ready = 1'b0;
        n_vec++; if (pc_load !== 1'b1 || pc_next !== 32'h0040_0004) begin n_err++; $display("FAIL basic_load got=%b/%h exp=1/00400004", pc_load, pc_next); end
        n_vec++; if (ir_valid !== 1'b0) begin n_err++; $display("FAIL basic_valid_clear got=%b exp=0", ir_valid); end
        tick();
        n_vec++; if (pc_load !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL basic_after got=%b/%b exp=0/0", pc_load, busy); end
        exp_pc_next = 32'h0040_0004;
    endtask

    task automatic test_zero_wait();
        pc_addr = 32'h0040_0100; fetch_start = 1'b1;
        tick(); fetch_start = 1'b0;
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        tick(); imem_ack = 1'b0;
        for (int d = 0; d < 5; d++) begin
            n_vec++; if (ir_valid !== 1'b1 || ir_out !== 32'hDEAD_BEEF || pc_load !== 1'b0) begin n_err++; $display("FAIL zw_hold d=%0d got=%b/%h/%b exp=1/deadbeef/0", d, ir_valid, ir_out, pc_load); end
            tick();
        end
        ir_ready = 1'b1;
        tick(); ir_ready = 1'b0;
        n_vec++; if (pc_load !== 1'b1 || pc_next !== 32'h0040_0104) begin n_err++; $display("FAIL zw_load got=%b/%h exp=1/00400104", pc_load, pc_next); end
        exp_pc_next = 32'h0040_0104;
        tick();
    endtask

    task automatic test_flush();
        pc_addr = 32'h0040_0200; fetch_start = 1'b1;
        tick(); fetch_start = 1'b0;
        flush = 1'b1;
        tick(); flush = 1'b0;
        n_vec++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL fl_req_held got=%b exp=1", imem_req); end
        tick();
        imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
        tick(); imem_ack = 1'b0;
        n_vec++; if ({imem_req, ir_valid, pc_load, busy} !== 4'b0) begin n_err++; $display("FAIL fl_done got=%b exp=0000", {imem_req, ir_valid, pc_load, busy}); end
        tick();
        n_vec++; if (pc_load !== 1'b0 || pc_next !== exp_pc_next) begin n_err++; $display("FAIL fl_no_load got=%b/%h exp=0/%h", pc_load, pc_next, exp_pc_next); end
    endtask

    task automatic test_err();
        pc_addr = 32'h0040_0010; fetch_start = 1'b1;
        tick(); fetch_start = 1'b0;
        imem_ack = 1'b1; imem_err = 1'b1;
        tick(); imem_ack = 1'b0; imem_err = 1'b0;
        n_vec++; if (fault !== 1'b1 || fault_addr !== 32'h0040_0010 || imem_req !== 1'b0) begin n_err++; $display("FAIL err_fault got=%b/%h/%b exp=1/00400010/0", fault, fault_addr, imem_req); end
        pc_addr = 32'h0040_0020; fetch_start = 1'b1;
        tick(); fetch_start = 1'b0;
        tick();
        n_vec++; if (imem_req !== 1'b0 || fault !== 1'b1 || fault_addr !== 32'h0040_0010) begin n_err++; $display("FAIL err_start_ignored got=%b/%b/%h exp=0/1/00400010", imem_req, fault, fault_addr); end
        flush = 1'b1;
        tick(); flush = 1'b0;
        n_vec++; if (fault !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL err_clear got=%b/%b exp=0/0", fault, busy); end
    endtask

    task automatic test_timeout();
        pc_addr = 32'h0040_0300; fetch_start = 1'b1;
        tick(); fetch_start = 1'b0;
        for (int c = 1; c <= TO; c++) begin
            n_vec++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL to_req c=%0d got=%b exp=1", c, imem_req); end
            tick();
        end
        n_vec++; if (imem_req !== 1'b0 || fault !== 1'b1 || fault_addr !== 32'h0040_0300) begin n_err++; $display("FAIL to_fault got=%b/%b/%h exp=0/1/00400300", imem_req, fault, fault_addr); end
        flush = 1'b1; tick(); flush = 1'b0;
        pc_addr = 32'h0040_0002; fetch_start = 1'b1;
        tick(); fetch_start = 1'b0;
        n_vec++; if (imem_req !== 1'b0 || fault !== 1'b1 || fault_addr !== 32'h0040_0002) begin n_err++; $display("FAIL mis_fault got=%b/%b/%h exp=0/1/00400002", imem_req, fault, fault_addr); end
        flush = 1'b1; tick(); flush = 1'b0;
    endtask

    task automatic test_wrap_rst();
        pc_addr = 32'hFFFF_FFFC; fetch_start = 1'b1;
        tick(); fetch_start = 1'b0;
        imem_ack = 1'b1; imem_rdata = 32'h0000_0013;
        tick(); imem_ack = 1'b0;
        ir_ready = 1'b1; tick(); ir_ready = 1'b0;
        n_vec++; if (pc_load !== 1'b1 || pc_next !== 32'h0) begin n_err++; $display("FAIL wrap got=%b/%h exp=1/00000000", pc_load, pc_next); end
        tick();
        pc_addr = 32'h0040_0400; fetch_start = 1'b1;
        tick(); fetch_start = 1'b0;
        #2 rst = 1'b1;
        #1;
        n_vec++; if (imem_req !== 1'b0 || imem_addr !== RPC) begin n_err++; $display("FAIL async_rst got=%b/%h exp=0/%h", imem_req, imem_addr, RPC); end
        tick(); rst = 1'b0; tick();
        n_vec++; if (busy !== 1'b0 || pc_next !== RPC + 32'd4) begin n_err++; $display("FAIL post_rst got=%b/%h exp=0/%h", busy, pc_next, RPC + 32'd4); end
        exp_pc_next = RPC + 32'd4;
    endtask

    // Model: each transaction's outcome follows from its kind alone:
    // 0 misaligned, 1 bus error, 2 timeout, 3 flushed, else a normal fetch.
    task automatic test_random();
        int          kind, lat, rd, ncyc;
        logic [31:0] a, data;
        for (int t = 0; t < 60; t++) begin
            kind = $urandom_range(0, 9);
            lat  = $urandom_range(1, TO);
            rd   = $urandom_range(0, 3);
            data = $urandom;
            a    = $urandom;
            a[1:0] = (kind == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            pc_addr = a; fetch_start = 1'b1;
            tick(); fetch_start = 1'b0;
            if (kind == 0) begin
                n_vec++; if (imem_req !== 1'b0 || fault !== 1'b1 || fault_addr !== a) begin n_err++; $display("FAIL rnd_mis t=%0d got=%b/%b/%h exp=0/1/%h", t, imem_req, fault, fault_addr, a); end
                flush = 1'b1; tick(); flush = 1'b0;
            end else begin
                ncyc = (kind == 2) ? TO : lat;
                for (int c = 1; c <= ncyc; c++) begin
                    n_vec++; if (imem_req !== 1'b1 || imem_addr !== a) begin n_err++; $display("FAIL rnd_req t=%0d c=%0d got=%b/%h exp=1/%h", t, c, imem_req, imem_addr, a); end
                    flush      = (kind == 3) && (c == 1);
                    imem_ack   = (kind != 2) && (c == lat);
                    imem_err   = (kind == 1) && (c == lat);
                    imem_rdata = data;
                    tick();
                    flush = 1'b0; imem_ack = 1'b0; imem_err = 1'b0;
                end
                n_vec++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL rnd_req_end t=%0d got=%b exp=0", t, imem_req); end
                if (kind == 1 || kind == 2) begin
                    n_vec++; if (fault !== 1'b1 || fault_addr !== a || ir_valid !== 1'b0) begin n_err++; $display("FAIL rnd_fault t=%0d got=%b/%h/%b exp=1/%h/0", t, fault, fault_addr, ir_valid, a); end
                    flush = 1'b1; tick(); flush = 1'b0;
                end else if (kind == 3) begin
                    n_vec++; if (ir_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL rnd_flush t=%0d got=%b/%b exp=0/0", t, ir_valid, busy); end
                    tick();
                end else begin
                    n_vec++; if (ir_valid !== 1'b1 || ir_out !== data) begin n_err++; $display("FAIL rnd_ir t=%0d got=%b/%h exp=1/%h", t, ir_valid, ir_out, data); end
                    for (int d = 0; d < rd; d++) begin
                        tick();
                        n_vec++; if (ir_valid !== 1'b1 || pc_load !== 1'b0) begin n_err++; $display("FAIL rnd_hold t=%0d got=%b/%b exp=1/0", t, ir_valid, pc_load); end
                    end
                    ir_ready = 1'b1; tick(); ir_ready = 1'b0;
                    exp_pc_next = a + 32'd4;
                    n_vec++; if (pc_load !== 1'b1 || ir_valid !== 1'b0) begin n_err++; $display("FAIL rnd_load t=%0d got=%b/%b exp=1/0", t, pc_load, ir_valid); end
                    tick();
                end
            end
            n_vec++; if (pc_next !== exp_pc_next || fault !== 1'b0 || busy !== 1'b0 || pc_load !== 1'b0) begin n_err++; $display("FAIL rnd_end t=%0d got=%h/%b/%b/%b exp=%h/0/0/0", t, pc_next, fault, busy, pc_load, exp_pc_next); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_wait();
        test_flush();
        test_err();
        test_timeout();
        test_wrap_rst();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
